// File: rtl/prio_arb_pkg.sv
// Shared types and helpers for the registered priority arbiter.
// Optional build macro: PRIO_ARB_ROUND_ROBIN_EN (rotating priority).
package prio_arb_pkg;

    // Default configuration of the arbiter.
    localparam int N_DEF        = 4;
    localparam int MAX_HOLD_DEF = 8;

    // Arbiter FSM states.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Index of the lowest set bit of a one-hot vector of up to 32 bits.
    // An all-zero vector maps to index 0.
    function automatic logic [4:0] onehot_to_idx(input logic [31:0] vec);
        logic [4:0] idx;
        logic       found;
        idx   = 5'd0;
        found = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (vec[i] && !found) begin
                idx   = 5'(i);
                found = 1'b1;
            end else begin
                idx   = idx;
            end
        end
        return idx;
    endfunction

endpackage : prio_arb_pkg

// File: rtl/prio_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// Optional build macro: PRIO_ARB_ROUND_ROBIN_EN (no effect on this file).
interface prio_arbiter_if #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
);
    logic [N-1:0]    req;
    logic [N-1:0]    grant;
    logic [ID_W-1:0] grant_id;
    logic            grant_valid;

    // Requester side: raises requests and observes the grant.
    modport master (
        output req,
        input  grant,
        input  grant_id,
        input  grant_valid
    );

    // Arbiter side: observes requests and drives the grant.
    modport slave (
        input  req,
        output grant,
        output grant_id,
        output grant_valid
    );
endinterface : prio_arbiter_if

// File: rtl/prio_find_first.sv
// Combinational search for the first unmasked set bit, starting at a given
// index and wrapping from N-1 back to 0. With start_i=0 this is a plain
// fixed-priority encoder (bit 0 highest).
// Optional build macro: PRIO_ARB_ROUND_ROBIN_EN (no effect on this file).
module prio_find_first #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    vec_i,
    input  logic [N-1:0]    mask_i,
    input  logic [ID_W-1:0] start_i,
    output logic            found_o,
    output logic [ID_W-1:0] idx_o
);

    logic [N-1:0] cand_s;

    assign cand_s = vec_i & ~mask_i;

    // Walk the candidates in rotated order and keep the first hit.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = int'(start_i) + k;
            if (j >= N) begin
                j = j - N;
            end else begin
                j = j;
            end
            if (cand_s[j] && !found_o) begin
                found_o = 1'b1;
                idx_o   = ID_W'(j);
            end else begin
                found_o = found_o;
            end
        end
    end

endmodule : prio_find_first

// File: rtl/prio_arbiter.sv
// Registered N-way arbiter with grant holding and a hold-limit timeout.
// A holder keeps the grant while it requests; on release or timeout the
// remaining requesters (owner masked) are re-arbitrated on the same edge,
// so hand-over has no idle bubble.
// Optional build macro: PRIO_ARB_ROUND_ROBIN_EN (rotating priority pointer);
// when undefined the priority is fixed with bit 0 highest.
module prio_arbiter
    import prio_arb_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int ID_W     = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    prio_arbiter_if.slave bus
);

    // Hold counter width; at least one bit even when the limit is disabled.
    localparam int HC_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

    arb_state_e      state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic            grant_valid_q, grant_valid_d;
    logic [HC_W-1:0] hold_q, hold_d;

    logic [N-1:0]    mask_s;
    logic [ID_W-1:0] start_s;
    logic            found_s;
    logic [ID_W-1:0] win_idx_s;
    logic            owner_req_s;
    logic            timeout_s;
    logic [N-1:0]    win_onehot_s;

`ifdef PRIO_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    // Successor of an index, wrapping N-1 back to 0.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] i);
        logic [ID_W-1:0] r;
        if (i == ID_W'(N - 1)) begin
            r = '0;
        end else begin
            r = i + ID_W'(1);
        end
        return r;
    endfunction

    assign start_s = rr_ptr_q;
`else
    assign start_s = '0;
`endif

    assign owner_req_s  = |(bus.req & grant_q);
    assign timeout_s    = (MAX_HOLD != 0) && (hold_q == HC_W'(MAX_HOLD));
    assign win_onehot_s = {{(N-1){1'b0}}, 1'b1} << win_idx_s;

    // The current owner is excluded from re-arbitration while busy.
    always_comb begin
        if (state_q == BUSY) begin
            mask_s = grant_q;
        end else begin
            mask_s = '0;
        end
    end

    prio_find_first #(
        .N    (N),
        .ID_W (ID_W)
    ) u_find (
        .vec_i   (bus.req),
        .mask_i  (mask_s),
        .start_i (start_s),
        .found_o (found_s),
        .idx_o   (win_idx_s)
    );

    // Next-state and next-output decision for the arbiter FSM.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        hold_d  = hold_q;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    state_d = BUSY;
                    grant_d = win_onehot_s;
                    hold_d  = HC_W'(1);
`ifdef PRIO_ARB_ROUND_ROBIN_EN
                    rr_ptr_d = wrap_inc(win_idx_s);
`endif
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                    hold_d  = '0;
                end
            end
            BUSY: begin
                if (owner_req_s && !timeout_s) begin
                    // Owner keeps the grant; count saturates at the limit.
                    if ((MAX_HOLD != 0) && (hold_q < HC_W'(MAX_HOLD))) begin
                        hold_d = hold_q + HC_W'(1);
                    end else begin
                        hold_d = hold_q;
                    end
                end else if (found_s) begin
                    // Release or timeout with another requester waiting.
                    grant_d = win_onehot_s;
                    hold_d  = HC_W'(1);
`ifdef PRIO_ARB_ROUND_ROBIN_EN
                    rr_ptr_d = wrap_inc(win_idx_s);
`endif
                end else if (owner_req_s) begin
                    // Timeout with nobody else waiting: re-grant the owner.
                    grant_d = grant_q;
                    hold_d  = HC_W'(1);
`ifdef PRIO_ARB_ROUND_ROBIN_EN
                    rr_ptr_d = wrap_inc(grant_id_q);
`endif
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                hold_d  = '0;
            end
        endcase
    end

    assign grant_id_d    = ID_W'(onehot_to_idx(32'(grant_d)));
    assign grant_valid_d = |grant_d;

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            hold_q        <= '0;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
            rr_ptr_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            hold_q        <= hold_d;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
            rr_ptr_q      <= rr_ptr_d;
`endif
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.grant_valid = grant_valid_q;

endmodule : prio_arbiter

// File: tb/tb_prio_arbiter.sv
// Directed bench for prio_arbiter with N=4, MAX_HOLD=4.
// Honours PRIO_ARB_ROUND_ROBIN_EN for the rotating-priority expectations.
module tb_prio_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    prio_arbiter_if #(.N(4)) bus ();

    prio_arbiter #(
        .N        (4),
        .MAX_HOLD (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input logic [3:0] g);
        logic [1:0] id;
        id = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (g[i]) id = 2'(i);
        end
        check_eq({tag, ".grant"}, 32'(bus.grant), 32'(g));
        check_eq({tag, ".valid"}, 32'(bus.grant_valid), 32'(g != 4'b0000));
        check_eq({tag, ".id"}, 32'(bus.grant_id), 32'(id));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.req  = 4'b1111;

        // Reset held with all requests active.
        step();
        step();
        check_grant("reset", 4'b0000);

        // Release reset with no requests: stays idle.
        bus.req = 4'b0000;
        rst_n   = 1'b1;
        step();
        check_grant("idle0", 4'b0000);

        // Fixed priority from IDLE, then a higher request must not pre-empt.
        bus.req = 4'b1010;
        step();
        check_grant("prio", 4'b0010);
        bus.req = 4'b1011;
        step();
        check_grant("nopreempt", 4'b0010);

        // Owner 1 releases; requester 3 takes over on the next edge.
        bus.req = 4'b1000;
        step();
        check_grant("handover", 4'b1000);

        // Sole owner releases: back to idle, then a fresh request.
        bus.req = 4'b0000;
        step();
        check_grant("idle_ret", 4'b0000);
        bus.req = 4'b0100;
        step();
        check_grant("regrant", 4'b0100);
        bus.req = 4'b0000;
        step();
        check_grant("idle2", 4'b0000);

        // Timeout hand-over between requesters 0 and 1.
        bus.req = 4'b0011;
        for (int s = 0; s < 12; s++) begin
            step();
            check_grant($sformatf("timeout%0d", s),
                        ((s / 4) % 2 == 0) ? 4'b0001 : 4'b0010);
        end

        // Lone requester times out and is re-granted with no gap.
        bus.req = 4'b0001;
        for (int s = 0; s < 10; s++) begin
            step();
            check_grant($sformatf("lone%0d", s), 4'b0001);
        end

        // Asynchronous reset mid-grant: outputs drop without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_grant("async_rst", 4'b0000);
        bus.req = 4'b1111;
        step();
        check_grant("rst_hold", 4'b0000);
        rst_n = 1'b1;

        // All requesting: rotation order depends on the priority mode.
        for (int s = 0; s < 20; s++) begin
            logic [3:0] exp_g;
            int         owner;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
            owner = (s / 4) % 4;
`else
            owner = (s / 4) % 2;
`endif
            exp_g = 4'b0001 << owner;
            step();
            check_grant($sformatf("all%0d", s), exp_g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_prio_arbiter

// File: doc/prio_arbiter.md
Name: prio_arbiter

Overview:
- Parametrised, registered successor to the 3-input combinational priority select.
- Arbitrates N request lines and issues one registered one-hot grant.
- A grant is held while its owner keeps requesting; a hold-limit counter forces hand-over.
- Sits in front of any shared resource (bus, memory port) used by several requesters.

Parameters:
- N, 4, number of requesters (N >= 2).
- MAX_HOLD, 8, max consecutive cycles one owner may hold the grant; 0 = unlimited.
- ID_W, $clog2(N), width of grant_id (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request lines; bit 0 is highest fixed priority.
- grant  output  N  registered one-hot grant, all-zero when idle.
- grant_id  output  ID_W  index of current owner, valid when grant_valid=1.
- grant_valid  output  1  high while any grant bit is set.

Behaviour:
- Reset (rst_n=0, async, immediate): grant=0, grant_id=0, grant_valid=0, state=IDLE, hold_cnt=0, rr_ptr=0.
- The FSM has two states, IDLE and BUSY.
- IDLE, req!=0: on the next edge, grant the highest-priority set bit, go to BUSY, hold_cnt=1. Latency is 1 cycle from req to grant.
- IDLE, req==0: stay in IDLE with all outputs zero.
- BUSY, req[owner]=1 and (MAX_HOLD==0 or hold_cnt<MAX_HOLD): keep the grant; hold_cnt increments, saturating at MAX_HOLD.
- BUSY, req[owner]=0 (release): on the same edge, re-arbitrate over req with the owner bit masked. This gives a bubble-free hand-over.
  - If a winner exists: grant it, hold_cnt=1.
  - If none: go to IDLE, grant=0.
- BUSY, hold_cnt==MAX_HOLD and req[owner]=1 (timeout): re-arbitrate with the owner masked.
  - If another requester exists: it wins, hold_cnt=1.
  - Otherwise: the owner is re-granted and hold_cnt=1. grant stays asserted with no gap.
- Requests from non-owners never pre-empt a holder before release or timeout.
- Simultaneous events:
  - New requests arriving in the same cycle as a release compete normally in that re-arbitration.
  - A release and a timeout in the same cycle are treated as a release.
- grant is always one-hot or zero, and grant_id always matches grant.
- hold_cnt width is $clog2(MAX_HOLD+1), minimum 1. No wrap is possible because the counter saturates.
- Reset asserted mid-grant: all outputs drop asynchronously. The first arbitration after deassertion behaves as from IDLE.

Optional Feature:
- Macro: PRIO_ARB_ROUND_ROBIN_EN.
- Defined: rotating priority.
  - rr_ptr (ID_W bits) is set to (winner+1) mod N on every new grant, including timeout re-grants.
  - The search starts at rr_ptr and wraps N-1 -> 0. The owner mask still applies.
- Undefined: fixed priority, bit 0 highest; rr_ptr is not instantiated.

Decomposition:
- Package prio_arb_pkg holds:
  - state typedef enum {IDLE, BUSY};
  - localparam defaults (N, MAX_HOLD);
  - function onehot_to_idx.
- One combinational sub-module, prio_find_first: inputs vector, mask, start index; outputs found, index.
  - Used for both fixed priority (start=0) and round-robin (start=rr_ptr).

Test Plan (N=4, MAX_HOLD=4):
- Reset: hold rst_n=0, drive req=4'b1111 -> grant=0, grant_valid=0. Assert rst_n mid-grant -> outputs zero within the same time step, with no clock edge needed.
- Fixed priority: req=4'b1010 from IDLE -> next edge grant=4'b0010, grant_id=1. Raise req[0] while req[1] is held -> grant stays 4'b0010.
- Hand-over: owner 1 drops req[1] while req[3]=1 -> next edge grant=4'b1000, with no idle cycle in between.
- Timeout: req=4'b0011 held constant.
  - grant=4'b0001 for exactly 4 cycles, then 4'b0010 for 4 cycles, then back to 4'b0001.
  - With req=4'b0001 only -> grant stays 4'b0001 continuously.
- Idle return: sole owner releases with req=0 -> next edge grant=0, grant_valid=0. Then req=4'b0100 -> grant=4'b0100 one cycle later.
- Round-robin (macro defined), req=4'b1111 held:
  - grants cycle 0,1,2,3,0 with each holding 4 cycles;
  - undefined -> grants alternate 0,1,0,1.
